// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scanner: active-low glyphs
// for {g,f,e,d,c,b,a} and the nibble-to-glyph decode function.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;  // lowercase b
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;  // lowercase d
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Map a hex nibble to its active-low segment pattern.
  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_seg_scan_hex_to_seg.sv
// Combinational 4-bit to 7-segment (active-low) decoder.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Pure lookup; the caller registers the result.
  always_comb seg = seg_decode(nibble);

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode seven-segment driver with per-digit
// enable, decimal points, leading-zero blanking, PWM brightness with a
// dark guard phase at the start of each slot, and per-frame snapshotting
// of all display inputs so a frame never mixes old and new content.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int TICK_DIV  = 100000,
  parameter int DUTY_BITS = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [4*DIGITS-1:0]    value,
  input  logic [DIGITS-1:0]      dp_mask,
  input  logic [DIGITS-1:0]      digit_en,
  input  logic                   blank_lz,
  input  logic [DUTY_BITS-1:0]   brightness,
  output logic [6:0]             cathode,
  output logic                   dp,
  output logic [DIGITS-1:0]      anode,
  output logic                   frame_start
);

  // Clocks per brightness phase; TICK_DIV is a multiple of 2**DUTY_BITS.
  localparam int PHASE_LEN = TICK_DIV >> DUTY_BITS;
  localparam int PS_W      = (TICK_DIV > 1)  ? $clog2(TICK_DIV)  : 1;
  localparam int PL_W      = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
  localparam int IDX_W     = (DIGITS > 1)    ? $clog2(DIGITS)    : 1;

  // Scan timing state. The phase is tracked by its own sub-counter so no
  // divider is needed to derive it from the prescaler.
  logic [PS_W-1:0]      presc_reg;
  logic [PL_W-1:0]      sub_reg;
  logic [DUTY_BITS-1:0] phase_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic                 first_reg;

  // Frame snapshot of the display inputs.
  logic [4*DIGITS-1:0]  value_sh_reg;
  logic [DIGITS-1:0]    dp_sh_reg;
  logic [DIGITS-1:0]    en_sh_reg;
  logic                 blz_sh_reg;
  logic [DUTY_BITS-1:0] bright_sh_reg;

  // Registered pin drivers.
  logic [DIGITS-1:0]    anode_reg, anode_next;
  logic [6:0]           cathode_reg, cathode_next;
  logic                 dp_reg, dp_next;
  logic                 frame_start_reg;

  logic                 slot_tick, sub_tick, snap;
  logic [3:0]           nib_sh [DIGITS];
  logic [DIGITS-1:0]    lz_mask;
  logic                 zero_run;
  logic [3:0]           cur_nib;
  logic [6:0]           cur_seg;
  logic                 lit;

  assign slot_tick = (presc_reg == PS_W'(TICK_DIV - 1));
  assign sub_tick  = (sub_reg == PL_W'(PHASE_LEN - 1));
  // Snapshot on the frame wrap, and once right after reset so the first
  // frame shows real data instead of the cleared shadows.
  assign snap      = first_reg || (slot_tick && (idx_reg == IDX_W'(DIGITS - 1)));

  // Prescaler, phase and digit index; slot length never depends on content.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_reg <= '0;
      sub_reg   <= '0;
      phase_reg <= '0;
      idx_reg   <= '0;
      first_reg <= 1'b1;
    end else begin
      first_reg <= 1'b0;
      if (slot_tick) begin
        presc_reg <= '0;
        sub_reg   <= '0;
        phase_reg <= '0;
        idx_reg   <= (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
      end else begin
        presc_reg <= presc_reg + PS_W'(1);
        if (sub_tick) begin
          sub_reg   <= '0;
          phase_reg <= phase_reg + DUTY_BITS'(1);
        end else begin
          sub_reg <= sub_reg + PL_W'(1);
        end
      end
    end
  end

  // Capture all display inputs together at the frame boundary.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      value_sh_reg  <= '0;
      dp_sh_reg     <= '0;
      en_sh_reg     <= '0;
      blz_sh_reg    <= 1'b0;
      bright_sh_reg <= '0;
    end else if (snap) begin
      value_sh_reg  <= value;
      dp_sh_reg     <= dp_mask;
      en_sh_reg     <= digit_en;
      blz_sh_reg    <= blank_lz;
      bright_sh_reg <= brightness;
    end
  end

  // Split the shadow value into per-digit nibbles.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
    assign nib_sh[gi] = value_sh_reg[4*gi +: 4];
  end

  // Walk down from the top digit; a digit is blanked while every nibble
  // from it upward is zero. Digit 0 always shows, so a zero value reads "0".
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run && (nib_sh[i] == 4'h0);
      lz_mask[i] = blz_sh_reg && zero_run;
    end
  end

  // Lit when enabled, past the guard phase, inside the duty window and not blanked.
  always_comb begin
    cur_nib = nib_sh[idx_reg];
    lit     = en_sh_reg[idx_reg] && (phase_reg != '0) &&
              (phase_reg <= bright_sh_reg) && !lz_mask[idx_reg];
  end

  hex_to_seg u_hex_to_seg (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  // Pin values for the current slot; everything dark when not lit.
  always_comb begin
    anode_next   = '1;
    cathode_next = SEG_BLANK;
    dp_next      = 1'b1;
    if (lit) begin
      anode_next   = ~(DIGITS'(1) << idx_reg);
      cathode_next = cur_seg;
      dp_next      = ~dp_sh_reg[idx_reg];
    end
  end

  // Register the pins so they never glitch; reset darkens them immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      anode_reg       <= '1;
      cathode_reg     <= SEG_BLANK;
      dp_reg          <= 1'b1;
      frame_start_reg <= 1'b0;
    end else begin
      anode_reg       <= anode_next;
      cathode_reg     <= cathode_next;
      dp_reg          <= dp_next;
      frame_start_reg <= snap;
    end
  end

  assign anode       = anode_reg;
  assign cathode     = cathode_reg;
  assign dp          = dp_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan (DIGITS=4, TICK_DIV=16, DUTY_BITS=2).
module tb_seven_seg_scan;

  localparam int DIGITS    = 4;
  localparam int TICK_DIV  = 16;
  localparam int DUTY_BITS = 2;
  localparam int FRAME     = DIGITS * TICK_DIV;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_mask = 4'h0;
  logic [3:0]  digit_en = 4'h0;
  logic        blank_lz = 1'b0;
  logic [1:0]  brightness = 2'd0;
  logic [6:0]  cathode;
  logic        dp;
  logic [3:0]  anode;
  logic        frame_start;

  int total = 0;
  int bad   = 0;

  seven_seg_scan #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .DUTY_BITS(DUTY_BITS)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .value       (value),
    .dp_mask     (dp_mask),
    .digit_en    (digit_en),
    .blank_lz    (blank_lz),
    .brightness  (brightness),
    .cathode     (cathode),
    .dp          (dp),
    .anode       (anode),
    .frame_start (frame_start)
  );

  always #5 clock = ~clock;

  // Reference glyphs, active-low {g,f,e,d,c,b,a}.
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: k counts clock edges since reset release. The pins after
  // edge k describe scan position k-1 (slot = position/16, phase = (position%16)/4),
  // using the inputs sampled at the most recent frame start (edge 1, then every 64).
  int          k = 0;
  logic [15:0] s_val = 16'h0;
  logic [3:0]  s_dp = 4'h0, s_en = 4'h0;
  logic        s_blz = 1'b0;
  logic [1:0]  s_bri = 2'd0;
  logic [3:0]  exp_anode = 4'hF;
  logic [6:0]  exp_cathode = 7'h7F;
  logic        exp_dp = 1'b1;
  logic        exp_fs = 1'b0;
  int          m_p, m_di, m_ph;
  logic [3:0]  m_nib, m_onehot;
  logic        m_blank, m_lit;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      k = 0;
      s_val = 16'h0; s_dp = 4'h0; s_en = 4'h0; s_blz = 1'b0; s_bri = 2'd0;
      exp_anode = 4'hF; exp_cathode = 7'h7F; exp_dp = 1'b1; exp_fs = 1'b0;
    end else begin
      k++;
      m_p  = k - 1;
      m_di = (m_p / TICK_DIV) % DIGITS;
      m_ph = (m_p % TICK_DIV) / (TICK_DIV / 4);
      m_nib = s_val[4*m_di +: 4];
      m_blank = (m_di >= 1) && s_blz && ((s_val >> (4*m_di)) == 16'h0);
      m_lit = s_en[m_di] && (m_ph >= 1) && (m_ph <= int'(s_bri)) && !m_blank;
      m_onehot = 4'b0001 << m_di;
      exp_anode   = m_lit ? ~m_onehot : 4'hF;
      exp_cathode = m_lit ? glyph[m_nib] : 7'h7F;
      exp_dp      = m_lit ? ~s_dp[m_di] : 1'b1;
      exp_fs      = (k == 1) || (k % FRAME == 0);
      if (exp_fs) begin
        s_val = value; s_dp = dp_mask; s_en = digit_en; s_blz = blank_lz; s_bri = brightness;
      end
    end
  end

  // Bounded wait for the next frame_start pulse (observed at a falling edge).
  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int w = 0; w < 200; w++) begin
      @(negedge clock);
      if (frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    value = 16'h1234; brightness = 2'd3; digit_en = 4'hF; dp_mask = 4'h0; blank_lz = 1'b0;
    repeat (3) @(negedge clock);
    total++; if (anode !== 4'hF) begin bad++; $display("FAIL reset_anode got=%h want=f", anode); end
    total++; if (cathode !== 7'h7F) begin bad++; $display("FAIL reset_cathode got=%h want=7f", cathode); end
    total++; if (dp !== 1'b1) begin bad++; $display("FAIL reset_dp got=%b want=1", dp); end
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs got=%b want=0", frame_start); end
    $display("test_reset: outputs held dark during reset");
  endtask

  task automatic test_basic;
    int first_low = 0;
    reset_n = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clock);
      total++;
      if (anode !== exp_anode || cathode !== exp_cathode || dp !== exp_dp || frame_start !== exp_fs) begin
        bad++;
        $display("FAIL basic t=%0t got an=%h ca=%h dp=%b fs=%b want an=%h ca=%h dp=%b fs=%b",
                 $time, anode, cathode, dp, frame_start, exp_anode, exp_cathode, exp_dp, exp_fs);
      end
      if (first_low == 0 && anode[0] === 1'b0) first_low = c;
      if (anode === 4'b0111) begin
        total++;
        if (cathode !== 7'h79) begin bad++; $display("FAIL basic_slot3 got=%h want=79", cathode); end
      end
    end
    total++;
    if (first_low != 5) begin bad++; $display("FAIL basic_first_lit got=clock %0d want=clock 5", first_low); end
    $display("test_basic: 1234 scanned, first lit at clock %0d", first_low);
  endtask

  task automatic test_blanking;
    bit ok;
    int n_hi, n_wrong, n_d0;
    value = 16'h0050; blank_lz = 1'b1;
    wait_frame(ok);
    total++; if (!ok) begin bad++; $display("FAIL blank_wait got=no pulse want=pulse"); end
    n_hi = 0;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clock);
      total++;
      if (anode !== exp_anode || cathode !== exp_cathode || dp !== exp_dp || frame_start !== exp_fs) begin
        bad++;
        $display("FAIL blank t=%0t got an=%h ca=%h dp=%b fs=%b want an=%h ca=%h dp=%b fs=%b",
                 $time, anode, cathode, dp, frame_start, exp_anode, exp_cathode, exp_dp, exp_fs);
      end
      if (anode[3] === 1'b0 || anode[2] === 1'b0) n_hi++;
      if (anode === 4'b1101) begin
        total++; if (cathode !== 7'h12) begin bad++; $display("FAIL blank_d1 got=%h want=12", cathode); end
      end
      if (anode === 4'b1110) begin
        total++; if (cathode !== 7'h40) begin bad++; $display("FAIL blank_d0 got=%h want=40", cathode); end
      end
    end
    total++; if (n_hi != 0) begin bad++; $display("FAIL blank_upper got=%0d lit cycles want=0", n_hi); end
    value = 16'h0000;
    wait_frame(ok);
    total++; if (!ok) begin bad++; $display("FAIL blank_wait2 got=no pulse want=pulse"); end
    n_wrong = 0; n_d0 = 0;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clock);
      if (anode !== 4'hF && anode !== 4'b1110) n_wrong++;
      if (anode === 4'b1110) begin
        n_d0++;
        total++; if (cathode !== 7'h40) begin bad++; $display("FAIL zero_d0 got=%h want=40", cathode); end
      end
    end
    total++; if (n_wrong != 0) begin bad++; $display("FAIL zero_others got=%0d lit cycles want=0", n_wrong); end
    total++; if (n_d0 != 12) begin bad++; $display("FAIL zero_d0_count got=%0d want=12", n_d0); end
    $display("test_blanking: 0050 and 0000 blanked correctly");
    blank_lz = 1'b0;
  endtask

  task automatic test_brightness;
    bit ok;
    int n_lit;
    int per_d [4];
    value = 16'h1234; brightness = 2'd0;
    wait_frame(ok);
    total++; if (!ok) begin bad++; $display("FAIL bright0_wait got=no pulse want=pulse"); end
    n_lit = 0;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clock);
      if (anode !== 4'hF) n_lit++;
    end
    total++; if (n_lit != 0) begin bad++; $display("FAIL bright0 got=%0d lit cycles want=0", n_lit); end
    brightness = 2'd1;
    wait_frame(ok);
    total++; if (!ok) begin bad++; $display("FAIL bright1_wait got=no pulse want=pulse"); end
    for (int d = 0; d < 4; d++) per_d[d] = 0;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clock);
      total++;
      if (anode !== exp_anode || cathode !== exp_cathode || dp !== exp_dp || frame_start !== exp_fs) begin
        bad++;
        $display("FAIL bright1 t=%0t got an=%h ca=%h dp=%b fs=%b want an=%h ca=%h dp=%b fs=%b",
                 $time, anode, cathode, dp, frame_start, exp_anode, exp_cathode, exp_dp, exp_fs);
      end
      for (int d = 0; d < 4; d++) if (anode[d] === 1'b0) per_d[d]++;
    end
    for (int d = 0; d < 4; d++) begin
      total++;
      if (per_d[d] != 4) begin bad++; $display("FAIL bright1_d%0d got=%0d want=4", d, per_d[d]); end
    end
    $display("test_brightness: dark at 0, 4/16 duty at 1");
  endtask

  task automatic test_snapshot;
    bit ok;
    int gap, n_new, n_d0;
    value = 16'h1234; brightness = 2'd3;
    wait_frame(ok);
    total++; if (!ok) begin bad++; $display("FAIL snap_wait got=no pulse want=pulse"); end
    repeat (20) @(negedge clock);
    value = 16'hABCD;
    gap = 20; n_new = 0; ok = 1'b0;
    while (gap < 200) begin
      @(negedge clock);
      gap++;
      total++;
      if (anode !== exp_anode || cathode !== exp_cathode || dp !== exp_dp || frame_start !== exp_fs) begin
        bad++;
        $display("FAIL snap t=%0t got an=%h ca=%h dp=%b fs=%b want an=%h ca=%h dp=%b fs=%b",
                 $time, anode, cathode, dp, frame_start, exp_anode, exp_cathode, exp_dp, exp_fs);
      end
      if (cathode === 7'h08 || cathode === 7'h03 || cathode === 7'h46 || cathode === 7'h21) n_new++;
      if (frame_start === 1'b1) begin ok = 1'b1; break; end
    end
    total++; if (!ok || gap != FRAME) begin bad++; $display("FAIL snap_period got=%0d want=%0d", gap, FRAME); end
    total++; if (n_new != 0) begin bad++; $display("FAIL snap_early got=%0d new-glyph cycles want=0", n_new); end
    n_d0 = 0;
    for (int c = 0; c < TICK_DIV; c++) begin
      @(negedge clock);
      if (anode === 4'b1110) begin
        n_d0++;
        total++; if (cathode !== 7'h21) begin bad++; $display("FAIL snap_d0 got=%h want=21", cathode); end
      end
    end
    total++; if (n_d0 != 12) begin bad++; $display("FAIL snap_d0_count got=%0d want=12", n_d0); end
    $display("test_snapshot: ABCD appeared only after frame_start, period %0d", gap);
  endtask

  task automatic test_enable_dp;
    bit ok;
    int n_off, n_dp_bad, n_dp, first_d2;
    value = 16'h1234; digit_en = 4'b0101; dp_mask = 4'b0001;
    wait_frame(ok);
    total++; if (!ok) begin bad++; $display("FAIL en_wait got=no pulse want=pulse"); end
    n_off = 0; n_dp_bad = 0; n_dp = 0; first_d2 = 0;
    for (int c = 1; c <= FRAME; c++) begin
      @(negedge clock);
      total++;
      if (anode !== exp_anode || cathode !== exp_cathode || dp !== exp_dp || frame_start !== exp_fs) begin
        bad++;
        $display("FAIL en_dp t=%0t got an=%h ca=%h dp=%b fs=%b want an=%h ca=%h dp=%b fs=%b",
                 $time, anode, cathode, dp, frame_start, exp_anode, exp_cathode, exp_dp, exp_fs);
      end
      if (anode[1] === 1'b0 || anode[3] === 1'b0) n_off++;
      if (dp === 1'b0) n_dp++;
      if (dp === 1'b0 && anode[0] !== 1'b0) n_dp_bad++;
      if (first_d2 == 0 && anode[2] === 1'b0) first_d2 = c;
    end
    total++; if (n_off != 0) begin bad++; $display("FAIL en_disabled got=%0d lit cycles want=0", n_off); end
    total++; if (n_dp_bad != 0) begin bad++; $display("FAIL en_dp_stray got=%0d want=0", n_dp_bad); end
    total++; if (n_dp != 12) begin bad++; $display("FAIL en_dp_count got=%0d want=12", n_dp); end
    total++; if (first_d2 != 37) begin bad++; $display("FAIL en_slot_len got=%0d want=37", first_d2); end
    $display("test_enable_dp: digits 1,3 dark, dp on digit 0 only");
    digit_en = 4'hF; dp_mask = 4'h0;
  endtask

  task automatic test_random;
    int changes = 0;
    for (int c = 0; c < 6 * FRAME; c++) begin
      @(negedge clock);
      total++;
      if (anode !== exp_anode || cathode !== exp_cathode || dp !== exp_dp || frame_start !== exp_fs) begin
        bad++;
        $display("FAIL random t=%0t got an=%h ca=%h dp=%b fs=%b want an=%h ca=%h dp=%b fs=%b",
                 $time, anode, cathode, dp, frame_start, exp_anode, exp_cathode, exp_dp, exp_fs);
      end
      if ($urandom_range(0, 19) == 0) begin
        changes++;
        value      = 16'($urandom) >> (4 * $urandom_range(0, 4));
        dp_mask    = 4'($urandom);
        digit_en   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
        blank_lz   = 1'($urandom_range(0, 1));
        brightness = 2'($urandom);
      end
    end
    $display("test_random: %0d random input changes over 6 frames", changes);
  endtask

  task automatic test_async_reset;
    bit ok;
    int first_c = 0;
    logic [3:0] first_an = 4'hF;
    value = 16'h1234; digit_en = 4'hF; dp_mask = 4'h0; blank_lz = 1'b0; brightness = 2'd3;
    wait_frame(ok);
    total++; if (!ok) begin bad++; $display("FAIL arst_wait got=no pulse want=pulse"); end
    repeat (40) @(posedge clock);
    #2;
    total++; if (anode !== 4'b1011) begin bad++; $display("FAIL arst_pre got=%h want=b", anode); end
    reset_n = 1'b0;
    #1;
    total++; if (anode !== 4'hF) begin bad++; $display("FAIL arst_anode got=%h want=f", anode); end
    total++; if (cathode !== 7'h7F) begin bad++; $display("FAIL arst_cathode got=%h want=7f", cathode); end
    total++; if (dp !== 1'b1) begin bad++; $display("FAIL arst_dp got=%b want=1", dp); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clock);
      total++;
      if (anode !== exp_anode || cathode !== exp_cathode || dp !== exp_dp || frame_start !== exp_fs) begin
        bad++;
        $display("FAIL arst t=%0t got an=%h ca=%h dp=%b fs=%b want an=%h ca=%h dp=%b fs=%b",
                 $time, anode, cathode, dp, frame_start, exp_anode, exp_cathode, exp_dp, exp_fs);
      end
      if (first_c == 0 && anode !== 4'hF) begin first_c = c; first_an = anode; end
    end
    total++;
    if (first_an !== 4'b1110 || first_c != 5) begin
      bad++; $display("FAIL arst_restart got=an %h at clock %0d want=an e at clock 5", first_an, first_c);
    end
    $display("test_async_reset: blanked without clock, restarted at digit 0");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_blanking();
    test_brightness();
    test_snapshot();
    test_enable_dp();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Parametrised time-multiplexed driver for a common-anode seven-segment display bank. It replaces the fixed 8-digit scanner with these additions:
- configurable digit count and slot length
- per-digit enable and decimal point
- leading-zero blanking
- PWM brightness with an anti-ghosting guard phase
- tear-free frame snapshotting

It sits between the top-level datapath (value to show) and the board's anode/cathode pins.

## Interface
- DIGITS, 8: number of digits scanned; value width is 4*DIGITS.
- TICK_DIV, 100000: clock cycles per digit slot; must be a multiple of 2**DUTY_BITS.
- DUTY_BITS, 4: brightness resolution; slot is split into 2**DUTY_BITS phases.
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- value  in  4*DIGITS  hex nibbles, digit 0 = bits [3:0]
- dp_mask  in  DIGITS  1 = light decimal point of that digit
- digit_en  in  DIGITS  1 = digit may be lit
- blank_lz  in  1  1 = suppress leading zeros
- brightness  in  DUTY_BITS  lit phases per slot; 0 = dark
- cathode  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- anode  out  DIGITS  digit select, active-low, at most one bit low
- frame_start  out  1  one-cycle pulse when a new snapshot is taken

## Operation
- **Prescaler.** Counts 0..TICK_DIV-1 and wraps. Terminal count is the slot tick.
- **Digit index.** Advances 0..DIGITS-1 on each slot tick and wraps to 0.
- **Phase.** phase = prescaler / (TICK_DIV >> DUTY_BITS), range 0..2**DUTY_BITS-1.
- **Snapshot.** value, dp_mask, digit_en, blank_lz and brightness are captured into shadow registers:
  - on the cycle the index wraps DIGITS-1 -> 0;
  - on the first clock after reset release.
  - frame_start pulses on that same cycle.
  - Inputs changed mid-frame have no visible effect until the next snapshot.
- **Lit condition** for the current slot digit i. All of the following must hold:
  - shadow digit_en[i] = 1;
  - phase >= 1 (phase 0 is the ghosting guard; anodes are always off);
  - phase <= shadow brightness;
  - the digit is not leading-zero-blanked.
- **Leading-zero blanking.** Digit i (i >= 1) is blanked when shadow blank_lz = 1 and every shadow nibble i..DIGITS-1 is 0. Digit 0 is never blanked.
- **When lit:**
  - anode = all ones except bit i, which is 0;
  - cathode = hex decode of nibble i (0-F, standard glyphs, lowercase b/d);
  - dp = ~dp_mask[i].
- **When not lit:** anode all ones, cathode 7'h7F, dp 1.
- **Brightness.** Brightness 2**DUTY_BITS-1 gives the maximum duty of (2**DUTY_BITS-1)/2**DUTY_BITS.
- **Slot timing is fixed.** Disabled or blanked digits still consume their slot, so refresh rate is independent of content.

## Timing
- Reset (asynchronous, immediate):
  - prescaler = 0, index = 0, shadows = 0;
  - anode all ones, cathode 7'h7F, dp 1, frame_start 0.
- All outputs are registered: they reflect the prescaler/index state of the previous cycle (1-clock latency).
- The first lit cycle after reset release depends on brightness. With DIGITS=4, TICK_DIV=16, DUTY_BITS=2, brightness=3, anode[0] first goes low at clock 5 after release.
- Frame period = DIGITS*TICK_DIV clocks. frame_start spacing equals exactly that period.
- Reset asserted mid-slot blanks outputs immediately. Scanning restarts at digit 0, phase 0.
- The snapshot and the index wrap occur in the same cycle. Digit 0 of the new frame uses the new snapshot.

## Structure
- Shared package seven_seg_pkg holds:
  - the segment encoding constants (SEG_0..SEG_F, SEG_BLANK = 7'h7F);
  - the hex-to-segment function.
- One sub-module, hex_to_seg: combinational 4-bit to 7-segment active-low decoder, instantiated once on the muxed nibble.
- Top-level contents: prescaler, index, shadow registers, leading-zero mask (combinational over shadow nibbles), lit logic, output registers.

## Test plan
All scenarios use DIGITS=4, TICK_DIV=16, DUTY_BITS=2.

1. Hold reset_n=0 -> anode 4'hF, cathode 7'h7F, dp 1. Release with value 16'h1234, brightness 3, digit_en 4'hF -> slot 0:
   - phase 0: anode 4'hF;
   - phases 1-3: anode 4'b1110, cathode 7'h19 ('4');
   - slot 3 shows 7'h79 ('1').
2. value 16'h0050, blank_lz 1 -> digits 3 and 2 never lit; digit 1 shows 7'h12 ('5'); digit 0 shows 7'h40. With value 16'h0000, only digit 0 is lit, showing 7'h40.
3. brightness 0 -> anode 4'hF for a whole frame. brightness 1 -> each digit lit exactly 4 of 16 cycles.
4. Change value from 16'h1234 to 16'hABCD during slot 1 -> digits still show 1234 until the frame_start pulse, then show ABCD. frame_start pulses every 64 clocks.
5. digit_en 4'b0101, dp_mask 4'b0001:
   - anode[1] and anode[3] never low;
   - dp low only while anode[0] is low;
   - slots 1 and 3 stay 16 clocks long.
6. Assert reset_n low during slot 2, phase 2 -> outputs blank in the same cycle with no clock edge. After release, the first lit digit is digit 0.
